// File: rtl/bitty_core.sv
// bitty_core -- tiny multi-cycle accumulator-style processor core.
//
// One instruction at a time walks IDLE -> LOAD -> EXEC -> WB -> IDLE.
//   IDLE : waits for run, latches the instruction word.
//   LOAD : S <= R[Rx].
//   EXEC : C <= ALU(S, B), carry flag updated by the ALU op.
//   WB   : done high for this cycle; R[Rx] <= C on the exiting edge.
// Illegal formats (fmt 1x) still walk every state but change nothing.
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high reset
//   run        start request, only looked at in IDLE
//   d_instr    16-bit instruction word, captured on the accepting edge
//   dbg_sel    register index for the debug read port
//   done       one-cycle pulse while in WB
//   busy       high whenever the core is not in IDLE
//   d_out      result register C
//   carry_out  carry flag
//   dbg_out    combinational read of R[dbg_sel]
module bitty_core #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       d_instr,
  input  logic [2:0]        dbg_sel,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] d_out,
  output logic              carry_out,
  output logic [DATA_W-1:0] dbg_out
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [15:0]       ir_r;
  logic [DATA_W-1:0] s_r;
  logic [DATA_W-1:0] c_r;
  logic              carry_r;
  logic [DATA_W-1:0] regs_r [NREGS];

  logic [2:0]        rx_s;
  logic [2:0]        ry_s;
  logic [7:0]        imm8_s;
  logic [2:0]        op_s;
  logic [1:0]        fmt_s;
  logic              legal_s;
  logic [DATA_W-1:0] b_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_carry_s;

  // Instruction field decode from the latched instruction word.
  assign rx_s    = ir_r[15:13];
  assign ry_s    = ir_r[12:10];
  assign imm8_s  = ir_r[12:5];
  assign op_s    = ir_r[4:2];
  assign fmt_s   = ir_r[1:0];
  assign legal_s = ~fmt_s[1];

  // Second operand: register (fmt 00) or zero-extended immediate.
  // B is read during EXEC, before any write-back of this instruction,
  // so Rx==Ry sees the pre-instruction value on both operands.
  always_comb begin
    b_s = '0;
    if (fmt_s == 2'b00) begin
      b_s = regs_r[ry_s];
    end else begin
      b_s[7:0] = imm8_s;
    end
  end

  // One extra bit on the sum captures the ADD carry-out.
  assign sum_s = {1'b0, s_r} + {1'b0, b_s};

  // ALU: result and carry for each op; CMP leaves the carry alone.
  always_comb begin
    alu_res_s   = '0;
    alu_carry_s = 1'b0;
    case (op_s)
      3'b000: begin
        alu_res_s   = sum_s[DATA_W-1:0];
        alu_carry_s = sum_s[DATA_W];
      end
      3'b001: begin
        alu_res_s   = s_r - b_s;
        alu_carry_s = (s_r < b_s);
      end
      3'b010: alu_res_s = s_r & b_s;
      3'b011: alu_res_s = s_r | b_s;
      3'b100: alu_res_s = s_r ^ b_s;
      3'b101: alu_res_s = s_r << b_s[SH_W-1:0];
      3'b110: alu_res_s = s_r >> b_s[SH_W-1:0];
      3'b111: begin
        alu_carry_s = carry_r;
        if (s_r == b_s) begin
          alu_res_s = '0;
        end else if (s_r > b_s) begin
          alu_res_s = {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
          alu_res_s = {{(DATA_W-2){1'b0}}, 2'b10};
        end
      end
      default: begin
        alu_res_s   = '0;
        alu_carry_s = carry_r;
      end
    endcase
  end

  // Next-state logic: only IDLE waits on run, the rest advance every cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_EXEC;
      ST_EXEC: state_s = ST_WB;
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Instruction register: captured only on the edge that accepts run.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_r <= 16'h0000;
    end else if ((state_r == ST_IDLE) && run) begin
      ir_r <= d_instr;
    end
  end

  // Datapath registers: S loaded in LOAD, C and carry updated in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_r     <= '0;
      c_r     <= '0;
      carry_r <= 1'b0;
    end else begin
      if (state_r == ST_LOAD) begin
        s_r <= regs_r[rx_s];
      end
      if ((state_r == ST_EXEC) && legal_s) begin
        c_r     <= alu_res_s;
        carry_r <= alu_carry_s;
      end
    end
  end

  // Register file: written from C as WB is left, legal formats only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if ((state_r == ST_WB) && legal_s) begin
      regs_r[rx_s] <= c_r;
    end
  end

  // Outputs come straight from registers (state, C, carry, register file).
  assign done      = (state_r == ST_WB);
  assign busy      = (state_r != ST_IDLE);
  assign d_out     = c_r;
  assign carry_out = carry_r;
  assign dbg_out   = regs_r[dbg_sel];

endmodule

// File: tb/tb_bitty_core.sv
// Scoreboard bench for bitty_core: three instances (DATA_W 16, 8, 32) share
// the same stimulus; a width-generic reference model predicts each lane.
module tb_bitty_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        run;
  logic [15:0] d_instr;
  logic [2:0]  dbg_sel;

  logic        done_v  [3];
  logic        busy_v  [3];
  logic        carry_v [3];
  logic [15:0] dout16, dbg16;
  logic [7:0]  dout8,  dbg8;
  logic [31:0] dout32, dbg32;
  logic [31:0] dout_v [3];
  logic [31:0] dbg_v  [3];

  assign dout_v[0] = {16'd0, dout16};
  assign dout_v[1] = {24'd0, dout8};
  assign dout_v[2] = dout32;
  assign dbg_v[0]  = {16'd0, dbg16};
  assign dbg_v[1]  = {24'd0, dbg8};
  assign dbg_v[2]  = dbg32;

  bitty_core #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset(reset), .run(run), .d_instr(d_instr), .dbg_sel(dbg_sel),
    .done(done_v[0]), .busy(busy_v[0]), .d_out(dout16), .carry_out(carry_v[0]),
    .dbg_out(dbg16));

  bitty_core #(.DATA_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .run(run), .d_instr(d_instr), .dbg_sel(dbg_sel),
    .done(done_v[1]), .busy(busy_v[1]), .d_out(dout8), .carry_out(carry_v[1]),
    .dbg_out(dbg8));

  bitty_core #(.DATA_W(32)) u_dut32 (
    .clk(clk), .reset(reset), .run(run), .d_instr(d_instr), .dbg_sel(dbg_sel),
    .done(done_v[2]), .busy(busy_v[2]), .d_out(dout32), .carry_out(carry_v[2]),
    .dbg_out(dbg32));

  typedef struct packed {
    logic [31:0]      done_cyc;
    logic [2:0]       rx;
    logic [2:0][31:0] c;
    logic [2:0]       cy;
    logic [2:0][31:0] r;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Edge counter used to time-stamp expected done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state, one register file per lane.
  logic [31:0] mr  [3][8];
  logic [31:0] mc  [3];
  logic        mcy [3];

  function automatic int lw(input int l);
    return (l == 0) ? 16 : ((l == 1) ? 8 : 32);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 8; i++) mr[l][i] = 32'd0;
      mc[l]  = 32'd0;
      mcy[l] = 1'b0;
    end
  endtask

  // Architectural effect of one instruction on every lane, plain arithmetic.
  task automatic model_step(input logic [15:0] ins, output exp_t e);
    logic [2:0] rx, ry, op;
    logic [1:0] fmt;
    longint unsigned m, s, b, t, res;
    logic cy;
    rx  = ins[15:13];
    ry  = ins[12:10];
    op  = ins[4:2];
    fmt = ins[1:0];
    e   = '0;
    e.rx = rx;
    for (int l = 0; l < 3; l++) begin
      m = 64'd1 << lw(l);
      s = 64'(mr[l][rx]);
      b = (fmt == 2'b00) ? 64'(mr[l][ry]) : 64'(ins[12:5]);
      if (fmt == 2'b00 || fmt == 2'b01) begin
        cy  = 1'b0;
        res = 64'd0;
        case (op)
          3'd0: begin t = s + b; res = t % m; cy = (t >= m); end
          3'd1: begin res = (s + m - b) % m; cy = (s < b); end
          3'd2: res = s & b;
          3'd3: res = s | b;
          3'd4: res = s ^ b;
          3'd5: res = (s << (b % 64'(lw(l)))) % m;
          3'd6: res = s >> (b % 64'(lw(l)));
          default: begin
            res = (s == b) ? 64'd0 : ((s > b) ? 64'd1 : 64'd2);
            cy  = mcy[l];
          end
        endcase
        mr[l][rx] = 32'(res);
        mc[l]     = 32'(res);
        mcy[l]    = cy;
      end
      e.c[l]  = mc[l];
      e.cy[l] = mcy[l];
      e.r[l]  = mr[l][rx];
    end
  endtask

  function automatic logic [15:0] enc_i(input logic [2:0] rx, input logic [7:0] imm,
                                        input logic [2:0] op);
    return {rx, imm, op, 2'b01};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] rx, input logic [2:0] ry,
                                        input logic [2:0] op);
    return {rx, ry, 5'b00000, op, 2'b00};
  endfunction

  // Issue one instruction; junk on run/d_instr while the core is busy.
  // Returns just after the third edge following acceptance, so a following
  // issue() lands back-to-back (one instruction every 4 cycles).
  task automatic issue(input logic [15:0] ins);
    exp_t e;
    @(negedge clk);
    run     = 1'b1;
    d_instr = ins;
    dbg_sel = ins[15:13];
    model_step(ins, e);
    e.done_cyc = 32'(cyc + 3);
    sb.push_back(e);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      run     = 1'($urandom_range(0, 1));
      d_instr = 16'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      run     = 1'b0;
      d_instr = 16'($urandom);
    end
  endtask

  // Monitor: pops an expectation on every done pulse and checks the result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_v[0] || done_v[1] || done_v[2]) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 expected=0 (cyc=%0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), e.done_cyc);
          for (int l = 0; l < 3; l++)
            chk($sformatf("done_w%0d", lw(l)), 32'(done_v[l]), 32'd1);
          @(posedge clk);
          #1;
          for (int l = 0; l < 3; l++) begin
            chk($sformatf("d_out_w%0d", lw(l)), dout_v[l], e.c[l]);
            chk($sformatf("carry_w%0d", lw(l)), 32'(carry_v[l]), 32'(e.cy[l]));
            chk($sformatf("R%0d_w%0d", e.rx, lw(l)), dbg_v[l], e.r[l]);
            chk($sformatf("busy_after_wb_w%0d", lw(l)), 32'(busy_v[l]), 32'd0);
          end
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("%s_busy_w%0d", tag, lw(l)), 32'(busy_v[l]), 32'd0);
      chk($sformatf("%s_done_w%0d", tag, lw(l)), 32'(done_v[l]), 32'd0);
      chk($sformatf("%s_d_out_w%0d", tag, lw(l)), dout_v[l], 32'd0);
      chk($sformatf("%s_carry_w%0d", tag, lw(l)), 32'(carry_v[l]), 32'd0);
      chk($sformatf("%s_dbg_w%0d", tag, lw(l)), dbg_v[l], 32'd0);
    end
  endtask

  // Stimulus.
  initial begin
    logic [15:0] ins;
    reset   = 1'b1;
    run     = 1'b0;
    d_instr = 16'h0000;
    dbg_sel = 3'd1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;

    // First run accepted on the first edge with reset low.
    issue(enc_i(3'd1, 8'd5, 3'd0));          // ADD R1, #5
    idle(1);
    issue(enc_i(3'd2, 8'd1, 3'd1));          // SUB R2, #1 -> all ones, borrow
    issue(enc_i(3'd2, 8'd1, 3'd0));          // ADD R2, #1 -> 0, carry
    issue(enc_i(3'd3, 8'd3, 3'd0));          // R3 = 3
    issue(enc_i(3'd4, 8'd7, 3'd0));          // R4 = 7
    issue(enc_r(3'd3, 3'd4, 3'd1));          // SUB R3,R4 -> -4, borrow
    issue(enc_r(3'd4, 3'd3, 3'd7));          // CMP R4,R3 -> 2
    issue(enc_r(3'd1, 3'd1, 3'd0));          // ADD R1,R1 (Rx==Ry)
    issue(enc_r(3'd1, 3'd1, 3'd7));          // CMP equal -> 0
    issue(enc_i(3'd6, 8'h12, 3'd0));         // build R6 = 0x1234
    issue(enc_i(3'd6, 8'd8, 3'd5));
    issue(enc_i(3'd6, 8'h34, 3'd3));
    issue({3'd6, 8'hAB, 3'b000, 2'b11});     // illegal fmt 11
    issue({3'd6, 8'h01, 3'b101, 2'b10});     // illegal fmt 10
    issue(enc_i(3'd6, 8'd4, 3'd6));          // SHR R6, #4
    issue(enc_i(3'd1, 8'hFF, 3'd4));         // XOR
    issue(enc_i(3'd1, 8'h0F, 3'd2));         // AND
    idle(2);

    // Reset during EXEC aborts the instruction.
    @(negedge clk);
    run     = 1'b1;
    d_instr = enc_i(3'd5, 8'd9, 3'd0);
    dbg_sel = 3'd5;
    @(posedge clk);                          // accepted -> LOAD
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);                          // -> EXEC
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk_reset_state("abort");
    // Reset wins over run on the same edge.
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("reset_vs_run");
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;

    // Randomised traffic.
    for (int n = 0; n < 80; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 7) != 0) ins[1] = 1'b0;
      issue(ins);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(8);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
